// File: rtl/zsdram_pkg.sv
// Shared definitions for the SDRAM command sequencer: pin command codes,
// FSM state encoding, address field widths and the mode-register value.
package zsdram_pkg;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int COL_W  = 9;
  localparam int DATA_W = 16;
  localparam int A10    = 10;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam logic [ADDR_W-1:0] MODE_REG  = 13'h030;
  localparam logic [ADDR_W-1:0] ALL_BANKS = 13'h0400;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_LMR,
    S_REF, S_ACT, S_WR, S_RD, S_CAP, S_DONE, S_WAIT_REL
  } state_t;

  typedef struct packed {
    logic [BA_W-1:0]   ba;
    logic [ADDR_W-1:0] row;
    logic [COL_W-1:0]  col;
  } sdr_addr_t;

  // Column address with A10 set, selecting auto-precharge.
  function automatic logic [ADDR_W-1:0] colAddr(input logic [COL_W-1:0] col);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[COL_W-1:0] = col;
    a[A10] = 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/zsdram_wait_cnt.sv
// Loadable down-counter shared by every timed wait of the sequencer.
// Loading N-1 and leaving on the zero flag gives a wait of exactly N cycles.
module zsdram_wait_cnt #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/zsdram_func_module.sv
// SDRAM command sequencer: turns a one-hot call into the init, refresh, single-word
// write or single-word read command sequence and signals completion with oDone.
module zsdram_func_module
  import zsdram_pkg::*;
#(
  parameter int T_INIT = 26700,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 9,
  parameter int T_MRD  = 2,
  parameter int T_RCD  = 3,
  parameter int T_WR   = 2,
  parameter int CL     = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    iCall,
  output logic                          oDone,
  input  logic [BA_W+ADDR_W+COL_W-1:0]  iAddr,
  input  logic [DATA_W-1:0]             iData,
  output logic [DATA_W-1:0]             oData,
  output logic                          sdr_cke,
  output logic [3:0]                    sdr_cmd,
  output logic [BA_W-1:0]               sdr_ba,
  output logic [ADDR_W-1:0]             sdr_addr,
  output logic [DATA_W-1:0]             sdr_dq_o,
  output logic                          sdr_dq_oe,
  input  logic [DATA_W-1:0]             sdr_dq_i
);

  localparam int CNT_W = $clog2(T_INIT + T_RFC + T_WR + T_RP + CL + 1);

  state_t            state, retState;
  sdr_addr_t         reqAddr;
  logic              isWrite;
  logic [BA_W-1:0]   bankReg;
  logic [COL_W-1:0]  colReg;
  logic [DATA_W-1:0] dataReg, dqIn;
  logic              cntLoad, cntZero;
  logic [CNT_W-1:0]  cntVal;

  assign reqAddr = iAddr;
  assign sdr_cke = 1'b1;

  // Every non-wait state reloads the counter with the length of the wait that follows it.
  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cntLoad = (state != S_WAIT);
    cntVal  = '0;
    case (state)
      S_IDLE:                   cntVal = CNT_W'(T_INIT - 1);
      S_INIT_PRE, S_CAP:        cntVal = CNT_W'(T_RP - 1);
      S_INIT_REF1, S_INIT_REF2,
      S_REF:                    cntVal = CNT_W'(T_RFC - 1);
      S_INIT_LMR:               cntVal = CNT_W'(T_MRD - 1);
      S_ACT:                    cntVal = CNT_W'(T_RCD - 1);
      S_WR:                     cntVal = CNT_W'(T_WR + T_RP - 1);
      S_RD:                     cntVal = CNT_W'(CL - 1);
      default:                  cntVal = '0;
    endcase
  end

  zsdram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cntLoad),
    .loadVal (cntVal),
    .zero    (cntZero)
  );

  // NOTE: the request and capture registers are reset too; they are a handful of flops, not a memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      retState  <= S_IDLE;
      isWrite   <= 1'b0;
      bankReg   <= '0;
      colReg    <= '0;
      dataReg   <= '0;
      dqIn      <= '0;
      oData     <= '0;
      oDone     <= 1'b0;
      sdr_cmd   <= CMD_NOP;
      sdr_ba    <= '0;
      sdr_addr  <= '0;
      sdr_dq_o  <= '0;
      sdr_dq_oe <= 1'b0;
    end else begin
      sdr_cmd   <= CMD_NOP;
      sdr_dq_oe <= 1'b0;
      oDone     <= 1'b0;
      dqIn      <= sdr_dq_i;
      case (state)
        S_IDLE: begin
          bankReg <= reqAddr.ba;
          colReg  <= reqAddr.col;
          dataReg <= iData;
          if (iCall[0]) begin
            state    <= S_WAIT;
            retState <= S_INIT_PRE;
          end else if (iCall[1]) begin
            state   <= S_REF;
            sdr_cmd <= CMD_REF;
          end else if (iCall[3] || iCall[2]) begin
            state    <= S_ACT;
            isWrite  <= iCall[3];
            sdr_cmd  <= CMD_ACT;
            sdr_ba   <= reqAddr.ba;
            sdr_addr <= reqAddr.row;
          end
        end
        S_INIT_PRE:  begin state <= S_WAIT; retState <= S_INIT_REF1; end
        S_INIT_REF1: begin state <= S_WAIT; retState <= S_INIT_REF2; end
        S_INIT_REF2: begin state <= S_WAIT; retState <= S_INIT_LMR;  end
        S_INIT_LMR,
        S_REF,
        S_WR:        begin state <= S_WAIT; retState <= S_DONE;      end
        S_ACT:       begin state <= S_WAIT; retState <= isWrite ? S_WR : S_RD; end
        S_RD:        begin state <= S_WAIT; retState <= S_CAP;       end
        S_CAP: begin
          // dqIn now holds what the device drove CL cycles after RD.
          oData    <= dqIn;
          state    <= S_WAIT;
          retState <= S_DONE;
        end
        S_WAIT: begin
          if (cntZero) begin
            state <= retState;
            case (retState)
              S_INIT_PRE: begin
                sdr_cmd  <= CMD_PRE;
                sdr_ba   <= '0;
                sdr_addr <= ALL_BANKS;
              end
              S_INIT_REF1, S_INIT_REF2: sdr_cmd <= CMD_REF;
              S_INIT_LMR: begin
                sdr_cmd  <= CMD_LMR;
                sdr_ba   <= '0;
                sdr_addr <= MODE_REG;
              end
              S_WR: begin
                sdr_cmd   <= CMD_WR;
                sdr_ba    <= bankReg;
                sdr_addr  <= colAddr(colReg);
                sdr_dq_o  <= dataReg;
                sdr_dq_oe <= 1'b1;
              end
              S_RD: begin
                sdr_cmd  <= CMD_RD;
                sdr_ba   <= bankReg;
                sdr_addr <= colAddr(colReg);
              end
              S_DONE:  oDone <= 1'b1;
              default: ;
            endcase
          end
        end
        S_DONE: state <= S_WAIT_REL;
        S_WAIT_REL: begin
          // A call held high after completion must not start the same sequence again.
          if (iCall == 4'b0000) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zsdram_func_module.sv
// Directed bench for zsdram_func_module with a small SDRAM model that stores written
// words, returns read data exactly CL cycles after RD, and checks pin-level timing.
module tb_zsdram_func_module;
  import zsdram_pkg::*;

  localparam int T_INIT = 26700;
  localparam int T_RP   = 3;
  localparam int T_RFC  = 9;
  localparam int T_MRD  = 2;
  localparam int T_RCD  = 3;
  localparam int T_WR   = 2;
  localparam int CL     = 3;
  localparam int LAT_WR  = 1 + 1 + T_RCD + 1 + T_WR + T_RP;
  localparam int LAT_RD  = 1 + 1 + T_RCD + 1 + CL + 1 + T_RP;
  localparam int LAT_REF = 1 + 1 + T_RFC;
  localparam logic [15:0] DQ_IDLE = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  iCall;
  logic        oDone;
  logic [23:0] iAddr;
  logic [15:0] iData, oData;
  logic        sdr_cke;
  logic [3:0]  sdr_cmd;
  logic [1:0]  sdr_ba;
  logic [12:0] sdr_addr;
  logic [15:0] sdr_dq_o;
  logic        sdr_dq_oe;
  logic [15:0] sdr_dq_i = 16'hDEAD;

  zsdram_func_module #(
    .T_INIT(T_INIT), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD),
    .T_RCD(T_RCD), .T_WR(T_WR), .CL(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .iCall(iCall), .oDone(oDone), .iAddr(iAddr),
    .iData(iData), .oData(oData), .sdr_cke(sdr_cke), .sdr_cmd(sdr_cmd),
    .sdr_ba(sdr_ba), .sdr_addr(sdr_addr), .sdr_dq_o(sdr_dq_o),
    .sdr_dq_oe(sdr_dq_oe), .sdr_dq_i(sdr_dq_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SDRAM model and pin monitor (samples on negedge) ----------------
  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        oe;
    logic [15:0] dqo;
  } cmd_rec_t;

  cmd_rec_t    cmdQ[$];
  int          doneQ[$];
  logic [15:0] mem [logic [23:0]];
  logic [12:0] openRow [4];
  int          actCyc [4];
  int          rdDue  = -1;
  int          lastRd = -100;
  logic [15:0] rdData;
  logic [23:0] key;

  always @(negedge clk) begin
    sdr_dq_i = (cyc == rdDue) ? rdData : DQ_IDLE;
    if (rst_n) begin
      if (sdr_cmd != CMD_NOP)
        cmdQ.push_back('{cyc, sdr_cmd, sdr_ba, sdr_addr, sdr_dq_oe, sdr_dq_o});
      if (oDone) doneQ.push_back(cyc);
      if (sdr_dq_oe) begin
        check("model oe_only_with_wr", sdr_cmd, CMD_WR);
        check("model oe_clear_after_rd", 32'((cyc - lastRd) > CL + 1), 1);
      end
      case (sdr_cmd)
        CMD_ACT: begin
          openRow[sdr_ba] = sdr_addr;
          actCyc[sdr_ba]  = cyc;
        end
        CMD_WR: begin
          check("model trcd_wr", 32'((cyc - actCyc[sdr_ba]) >= T_RCD), 1);
          key = {sdr_ba, openRow[sdr_ba], sdr_addr[8:0]};
          mem[key] = sdr_dq_o;
        end
        CMD_RD: begin
          check("model trcd_rd", 32'((cyc - actCyc[sdr_ba]) >= T_RCD), 1);
          key    = {sdr_ba, openRow[sdr_ba], sdr_addr[8:0]};
          rdData = mem.exists(key) ? mem[key] : 16'hBAD0;
          rdDue  = cyc + CL;
          lastRd = cyc;
        end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clearLogs();
    @(posedge clk);
    #1;
    cmdQ.delete();
    doneQ.delete();
  endtask

  // Drives a call for `hold` cycles (0 = until oDone) and reports call/done cycles.
  task automatic runCall(input string tag, input logic [3:0] call, input logic [23:0] addr,
                         input logic [15:0] data, input int hold, input int budget,
                         output int callCyc, output int doneCyc);
    clearLogs();
    @(negedge clk);
    iCall = call; iAddr = addr; iData = data;
    callCyc = cyc;
    doneCyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (hold > 0 && i + 1 >= hold) iCall = 4'b0000;
      if (oDone) begin
        doneCyc = cyc;
        break;
      end
    end
    iCall = 4'b0000;
    check({tag, " done_seen"}, 32'(doneCyc >= 0), 1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  call;
    logic [23:0] addr;
    logic [15:0] data;
    int          hold;
    int          lat;
    logic [3:0]  cmd1;
    logic [3:0]  cmd2;
    int          nCmd;
    logic        chkRd;
    logic [15:0] rd;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int callCyc, doneCyc, seen;
  logic [23:0] va;
  logic [12:0] expCol;

  initial begin
    vecs[0] = '{"ref",      4'b0010, 24'h0,                      16'h0000, 0, LAT_REF, CMD_REF, CMD_NOP, 1, 1'b0, 16'h0000};
    vecs[1] = '{"wr_a",     4'b1000, {2'd1, 13'h0ABC, 9'h012}, 16'hA5A5, 0, LAT_WR,  CMD_ACT, CMD_WR,  2, 1'b0, 16'h0000};
    vecs[2] = '{"rd_a",     4'b0100, {2'd1, 13'h0ABC, 9'h012}, 16'h0000, 0, LAT_RD,  CMD_ACT, CMD_RD,  2, 1'b1, 16'hA5A5};
    vecs[3] = '{"wr_b_drop",4'b1000, {2'd3, 13'h1FFF, 9'h1FF}, 16'h1234, 1, LAT_WR,  CMD_ACT, CMD_WR,  2, 1'b0, 16'h0000};
    vecs[4] = '{"wr_c_pri", 4'b1100, {2'd2, 13'h0001, 9'h000}, 16'h0F0F, 0, LAT_WR,  CMD_ACT, CMD_WR,  2, 1'b0, 16'h0000};
    vecs[5] = '{"rd_b_drop",4'b0100, {2'd3, 13'h1FFF, 9'h1FF}, 16'h0000, 1, LAT_RD,  CMD_ACT, CMD_RD,  2, 1'b1, 16'h1234};
    vecs[6] = '{"ref_pri",  4'b1110, {2'd2, 13'h0001, 9'h000}, 16'hFFFF, 0, LAT_REF, CMD_REF, CMD_NOP, 1, 1'b0, 16'h0000};
    vecs[7] = '{"rd_c",     4'b0100, {2'd2, 13'h0001, 9'h000}, 16'h0000, 0, LAT_RD,  CMD_ACT, CMD_RD,  2, 1'b1, 16'h0F0F};
    vecs[8] = '{"rd_a2",    4'b0100, {2'd1, 13'h0ABC, 9'h012}, 16'h0000, 0, LAT_RD,  CMD_ACT, CMD_RD,  2, 1'b1, 16'hA5A5};

    rst_n = 1'b0; iCall = 4'b0000; iAddr = '0; iData = '0;
    repeat (3) @(negedge clk);
    check("reset cmd", sdr_cmd, CMD_NOP);
    check("reset cke", sdr_cke, 1);
    check("reset done", oDone, 0);
    check("reset oe", sdr_dq_oe, 0);
    check("reset odata", oData, 0);
    check("reset addr", {sdr_ba, sdr_addr}, 0);
    check("reset dq_o", sdr_dq_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Power-up initialisation.
    runCall("init", 4'b0001, 24'h0, 16'h0, 0, T_INIT + 100, callCyc, doneCyc);
    check("init cmd_count", cmdQ.size(), 4);
    check("init done_count", doneQ.size(), 1);
    if (cmdQ.size() == 4) begin
      check("init pre", cmdQ[0].cmd, CMD_PRE);
      check("init nop_cycles", cmdQ[0].cyc - callCyc - 1, T_INIT);
      check("init pre_a10", cmdQ[0].addr[10], 1);
      check("init ref1", cmdQ[1].cmd, CMD_REF);
      check("init ref1_gap", cmdQ[1].cyc - cmdQ[0].cyc, T_RP + 1);
      check("init ref2", cmdQ[2].cmd, CMD_REF);
      check("init ref2_gap", cmdQ[2].cyc - cmdQ[1].cyc, T_RFC + 1);
      check("init lmr", cmdQ[3].cmd, CMD_LMR);
      check("init lmr_gap", cmdQ[3].cyc - cmdQ[2].cyc, T_RFC + 1);
      check("init lmr_addr", {cmdQ[3].ba, cmdQ[3].addr}, {2'b00, 13'h030});
      check("init done_gap", doneCyc - cmdQ[3].cyc, T_MRD + 1);
    end

    // Table-driven single sequences.
    for (int v = 0; v < NV; v++) begin
      runCall(vecs[v].name, vecs[v].call, vecs[v].addr, vecs[v].data, vecs[v].hold, 40,
              callCyc, doneCyc);
      va     = vecs[v].addr;
      expCol = {4'b0010, va[8:0]};
      check({vecs[v].name, " latency"}, doneCyc - callCyc, vecs[v].lat);
      check({vecs[v].name, " done_count"}, doneQ.size(), 1);
      check({vecs[v].name, " cmd_count"}, cmdQ.size(), vecs[v].nCmd);
      if (cmdQ.size() >= 1) begin
        check({vecs[v].name, " cmd1"}, cmdQ[0].cmd, vecs[v].cmd1);
        check({vecs[v].name, " cmd1_cycle"}, cmdQ[0].cyc - callCyc, 1);
      end
      if (vecs[v].nCmd == 2 && cmdQ.size() >= 2) begin
        check({vecs[v].name, " act_ba"}, cmdQ[0].ba, va[23:22]);
        check({vecs[v].name, " act_row"}, cmdQ[0].addr, va[21:9]);
        check({vecs[v].name, " cmd2"}, cmdQ[1].cmd, vecs[v].cmd2);
        check({vecs[v].name, " act_to_cmd2"}, cmdQ[1].cyc - cmdQ[0].cyc, T_RCD + 1);
        check({vecs[v].name, " cmd2_ba"}, cmdQ[1].ba, va[23:22]);
        check({vecs[v].name, " cmd2_addr"}, cmdQ[1].addr, expCol);
        if (vecs[v].cmd2 == CMD_WR) begin
          check({vecs[v].name, " wr_oe"}, cmdQ[1].oe, 1);
          check({vecs[v].name, " wr_dq"}, cmdQ[1].dqo, vecs[v].data);
        end
      end
      if (vecs[v].chkRd) check({vecs[v].name, " odata"}, oData, vecs[v].rd);
    end

    // All call bits high: init wins, and a held call is serviced only once.
    clearLogs();
    @(negedge clk);
    iCall = 4'b1111;
    callCyc = cyc;
    doneCyc = -1;
    for (int i = 0; i < T_INIT + 100; i++) begin
      @(negedge clk);
      if (oDone) begin
        doneCyc = cyc;
        break;
      end
    end
    check("all done_seen", 32'(doneCyc >= 0), 1);
    repeat (20) @(negedge clk);
    check("all done_count", doneQ.size(), 1);
    check("all cmd_count", cmdQ.size(), 4);
    if (cmdQ.size() >= 1) check("all first_is_pre", cmdQ[0].cmd, CMD_PRE);
    iCall = 4'b0000;
    repeat (2) @(negedge clk);
    runCall("wr_over_rd", 4'b1100, {2'd0, 13'h0123, 9'h045}, 16'h5A5A, 0, 40, callCyc, doneCyc);
    check("wr_over_rd latency", doneCyc - callCyc, LAT_WR);
    check("wr_over_rd cmd_count", cmdQ.size(), 2);
    if (cmdQ.size() >= 2) check("wr_over_rd cmd2", cmdQ[1].cmd, CMD_WR);

    // Reset during the WR cycle aborts at once and no oDone follows.
    clearLogs();
    @(negedge clk);
    iCall = 4'b1000; iAddr = {2'd2, 13'h0777, 9'h0AA}; iData = 16'hC3C3;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sdr_cmd == CMD_WR) begin
        seen = 1;
        break;
      end
    end
    check("rstmid wr_seen", seen, 1);
    #1;
    rst_n = 1'b0;
    iCall = 4'b0000;
    #1;
    check("rstmid cmd", sdr_cmd, CMD_NOP);
    check("rstmid oe", sdr_dq_oe, 0);
    check("rstmid done", oDone, 0);
    check("rstmid dq_o", sdr_dq_o, 0);
    @(posedge clk);
    #1;
    check("rstmid cmd_held", sdr_cmd, CMD_NOP);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("rstmid no_done", doneQ.size(), 0);
    runCall("ref_after_rst", 4'b0010, 24'h0, 16'h0, 0, 40, callCyc, doneCyc);
    check("ref_after_rst latency", doneCyc - callCyc, LAT_REF);
    if (cmdQ.size() >= 1) check("ref_after_rst cmd1", cmdQ[0].cmd, CMD_REF);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
